// File: rtl/uio_arb_pkg.sv
// uio_arb_pkg -- shared definitions for the uio bus arbiter.
//   uio_arb_state_e  : arbiter FSM states (IDLE, TURN, OWN)
//   NREQ_DEFAULT     : default number of requesters
//   MAX_HOLD_DEFAULT : default OWN-cycle limit when ARB_TIMEOUT_EN is defined
//   PIN_W            : width of the shared uio pin group
package uio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_OWN  = 2'd2
  } uio_arb_state_e;

  localparam int NREQ_DEFAULT     = 4;
  localparam int MAX_HOLD_DEFAULT = 15;
  localparam int PIN_W            = 8;

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin winner selection.
//   req   : request vector
//   ptr   : index of the last owner; the search starts at ptr+1 and wraps
//   gnt   : one-hot winner (all zero when no request)
//   valid : at least one request present
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  int rank;
  int best_rank;

  // Each requester gets a rank equal to its distance after ptr; the lowest
  // ranked active requester wins. Avoids computed vector indices.
  always_comb begin
    gnt       = '0;
    rank      = 0;
    best_rank = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      rank = (j - int'(ptr) - 1 + 2 * NREQ) % NREQ;
      if (req[j] && (rank < best_rank)) begin
        best_rank = rank;
        gnt       = '0;
        gnt[j]    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter -- shares one 8-bit uio pin group among NREQ requesters.
// Optional feature macro: ARB_TIMEOUT_EN (bounds each grant to MAX_HOLD OWN
// cycles and pulses timeout on a forced release).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   ena             : enable; low forces the bus idle
//   req, done       : per-requester request level / release pulse
//   wdata, woe      : per-requester output byte / drive mask (byte k = [8k+7:8k])
//   uio_in          : pad input; rdata is its one-cycle registered copy
//   uio_out, uio_oe : registered pad output / output enable
//   grant           : one-hot owner, high only in OWN
//   busy            : high in TURN and OWN
//   timeout         : one-cycle pulse after a forced release
//   dbg_state       : current FSM state
// Protocol: a requester holds req high until it sees its grant bit, drives
// wdata/woe while granted, and ends ownership by pulsing done or dropping req.
// IDLE picks a winner, TURN is a one-cycle bus turnaround with pins tri-stated,
// OWN forwards the owner's byte to the pins with one register of latency.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       done,
  input  logic [NREQ*PIN_W-1:0] wdata,
  input  logic [NREQ*PIN_W-1:0] woe,
  input  logic [PIN_W-1:0]      uio_in,
  output logic [PIN_W-1:0]      uio_out,
  output logic [PIN_W-1:0]      uio_oe,
  output logic [PIN_W-1:0]      rdata,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  timeout,
  output uio_arb_state_e        dbg_state
);

  localparam int PW = $clog2(NREQ);

  uio_arb_state_e     state_q, state_d;
  logic [NREQ-1:0]    owner_q;
  logic [PW-1:0]      ptr_q;
  logic [NREQ-1:0]    pick_gnt;
  logic               pick_valid;
  logic [PW-1:0]      pick_idx;
  logic               pick_load;
  logic [PIN_W-1:0]   owner_wdata, owner_woe;
  logic               owner_req, owner_done;
  logic               hold_hit;
  logic               timeout_d;
  logic [PIN_W-1:0]   uio_out_q, uio_oe_q, rdata_q;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (pick_gnt[j]) pick_idx = PW'(j);
    end
  end

  // Owner's byte, mask and control bits, selected by the stored one-hot owner.
  always_comb begin
    owner_wdata = '0;
    owner_woe   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (owner_q[j]) begin
        owner_wdata = owner_wdata | wdata[j*PIN_W +: PIN_W];
        owner_woe   = owner_woe   | woe[j*PIN_W +: PIN_W];
      end
    end
  end

  assign owner_req  = |(req & owner_q);
  assign owner_done = |(done & owner_q);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q;

  // hold_q counts completed OWN cycles; the MAX_HOLD-th OWN cycle is the last.
  assign hold_hit = (state_q == ST_OWN) && (hold_q == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if ((state_q == ST_OWN) && (state_d == ST_OWN)) begin
      hold_q <= hold_q + 8'd1;
    end else begin
      hold_q <= '0;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pick_load = 1'b0;
    timeout_d = 1'b0;
    if (!ena) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_d   = ST_TURN;
            pick_load = 1'b1;
          end
        end
        ST_TURN: state_d = ST_OWN;
        ST_OWN: begin
          if (owner_done || !owner_req || hold_hit) state_d = ST_IDLE;
          // A release the owner asked for in the same cycle is a normal one.
          timeout_d = hold_hit && owner_req && !owner_done;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      ptr_q     <= PW'(NREQ - 1);
      uio_out_q <= '0;
      uio_oe_q  <= '0;
      rdata_q   <= '0;
      timeout   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= uio_in;
      timeout <= timeout_d;
      // The pointer moves at selection time, so every release (normal,
      // forced or ena drop) leaves it past the owner.
      if (pick_load) begin
        owner_q <= pick_gnt;
        ptr_q   <= pick_idx;
      end
      // Pins follow the owner only while OWN continues; the entry edge and
      // the exit edge both load zero.
      if ((state_q == ST_OWN) && (state_d == ST_OWN)) begin
        uio_out_q <= owner_wdata;
        uio_oe_q  <= owner_woe;
      end else begin
        uio_out_q <= '0;
        uio_oe_q  <= '0;
      end
    end
  end

  assign grant     = (state_q == ST_OWN) ? owner_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign uio_out   = uio_out_q;
  assign uio_oe    = uio_oe_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter -- directed bench for uio_bus_arbiter (NREQ=4, MAX_HOLD=3).
// Inputs change and outputs are sampled on the falling edge.
module tb_uio_bus_arbiter;
  import uio_arb_pkg::*;

  localparam int N = 4;

  logic           clk, rst_n, ena;
  logic [N-1:0]   req, done;
  logic [N*8-1:0] wdata, woe;
  logic [7:0]     uio_in;
  logic [7:0]     uio_out, uio_oe, rdata;
  logic [N-1:0]   grant;
  logic           busy, timeout;
  uio_arb_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_g [8];
  logic       exp_t [8];
  logic [3:0] order [5];

  uio_bus_arbiter #(.NREQ(N), .MAX_HOLD(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req       (req),
    .done      (done),
    .wdata     (wdata),
    .woe       (woe),
    .uio_in    (uio_in),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe),
    .rdata     (rdata),
    .grant     (grant),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds reset for two cycles and releases it on a falling edge; the caller
  // sets up the next stimulus in the same time step.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ena   = 1'b0;
    req   = '0;
    done  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    req    = '0;
    done   = '0;
    wdata  = {8'h44, 8'h33, 8'hA5, 8'h11};
    woe    = {8'h0F, 8'hF0, 8'hFF, 8'h3C};
    uio_in = 8'h77;
    order  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_uio_out", 32'(uio_out), 32'h0);
    check("rst_uio_oe", 32'(uio_oe), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // single requester 1: grant in cycle 3, pins in cycle 4
    rst_n = 1'b1;
    ena   = 1'b1;
    req   = 4'b0010;
    @(negedge clk);
    check("c2_turn_state", 32'(dbg_state), 32'(ST_TURN));
    check("c2_grant", 32'(grant), 32'h0);
    check("c2_uio_oe", 32'(uio_oe), 32'h0);
    check("c2_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("c3_grant", 32'(grant), 32'h2);
    check("c3_uio_oe", 32'(uio_oe), 32'h0);
    @(negedge clk);
    check("c4_grant", 32'(grant), 32'h2);
    check("c4_uio_out", 32'(uio_out), 32'hA5);
    check("c4_uio_oe", 32'(uio_oe), 32'hFF);
    wdata[15:8] = 8'h5A;
    @(negedge clk);
    check("own_latency_uio_out", 32'(uio_out), 32'h5A);
    done = 4'b0010;
    req  = 4'b0000;
    @(negedge clk);
    check("rel_grant", 32'(grant), 32'h0);
    check("rel_uio_oe", 32'(uio_oe), 32'h0);
    check("rel_uio_out", 32'(uio_out), 32'h0);
    check("rel_busy", 32'(busy), 32'h0);
    done   = '0;
    uio_in = 8'hC3;
    @(negedge clk);
    check("idle_rdata", 32'(rdata), 32'hC3);

    // round robin with all requesting; non-owner done is ignored
    do_reset();
    ena = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_turn_grant", 32'(grant), 32'h0);
      check("rr_turn_busy", 32'(busy), 32'h1);
      @(negedge clk);
      check("rr_own1_grant", 32'(grant), 32'(order[i]));
      @(negedge clk);
      check("rr_own2_grant", 32'(grant), 32'(order[i]));
      done = 4'b1111;
      @(negedge clk);
      check("rr_idle_grant", 32'(grant), 32'h0);
      check("rr_idle_busy", 32'(busy), 32'h0);
      done = '0;
    end

    // ena drop while owner 2 holds the bus; pointer survives
    req = 4'b0100;
    @(negedge clk);
    check("ena_turn_grant", 32'(grant), 32'h0);
    @(negedge clk);
    check("ena_own_grant", 32'(grant), 32'h4);
    @(negedge clk);
    check("ena_own_uio_oe", 32'(uio_oe), 32'hF0);
    ena = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    check("ena_off_grant", 32'(grant), 32'h0);
    check("ena_off_uio_oe", 32'(uio_oe), 32'h0);
    check("ena_off_busy", 32'(busy), 32'h0);
    check("ena_off_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    check("ena_off_hold_grant", 32'(grant), 32'h0);
    ena = 1'b1;
    @(negedge clk);
    check("ena_back_turn", 32'(grant), 32'h0);
    @(negedge clk);
    check("ena_back_grant", 32'(grant), 32'h8);

    // req drops during TURN: one OWN cycle, then release
    req = 4'b0000;
    @(negedge clk);
    check("reqdrop_rel_grant", 32'(grant), 32'h0);
    req = 4'b0001;
    @(negedge clk);
    check("turn_drop_state", 32'(dbg_state), 32'(ST_TURN));
    req = 4'b0000;
    @(negedge clk);
    check("turn_drop_own", 32'(grant), 32'h1);
    @(negedge clk);
    check("turn_drop_rel", 32'(grant), 32'h0);
    check("turn_drop_busy", 32'(busy), 32'h0);

    // asynchronous reset in OWN
    req = 4'b0010;
    repeat (2) @(negedge clk);
    check("arst_pre_grant", 32'(grant), 32'h2);
    @(negedge clk);
    check("arst_pre_uio_oe", 32'(uio_oe), 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    check("arst_uio_oe", 32'(uio_oe), 32'h0);
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    uio_in = 8'h3C;
    req    = 4'b0000;
    @(negedge clk);
    check("arst_rdata_held", 32'(rdata), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_rdata", 32'(rdata), 32'h3C);
    check("arst_idle", 32'(dbg_state), 32'(ST_IDLE));

    // hold limit; done coinciding with the limit is a normal release
`ifdef ARB_TIMEOUT_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    req = 4'b0001;
    @(negedge clk);
    check("hold_turn_grant", 32'(grant), 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("hold_grant", 32'(grant), 32'(exp_g[i]));
      check("hold_timeout", 32'(timeout), 32'(exp_t[i]));
    end
    done = 4'b0001;
    @(negedge clk);
    check("hold_done_grant", 32'(grant), 32'h0);
    check("hold_done_timeout", 32'(timeout), 32'h0);
    done = '0;
    req  = '0;
    @(negedge clk);
    check("final_idle", 32'(dbg_state), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the uio pins (2..8).
REQ-002 Parameter MAX_HOLD, default 15, SHALL set the maximum number of OWN cycles per grant when the timeout feature is compiled in (1..255).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-005 ena  in  1  design-selected enable; low forces the bus idle.
REQ-006 req  in  NREQ  per-requester bus request, level.
REQ-007 done  in  NREQ  per-requester release pulse.
REQ-008 wdata  in  NREQ*8  per-requester output byte; requester k occupies bits [8k+7:8k].
REQ-009 woe  in  NREQ*8  per-requester pin direction mask; 1 means drive.
REQ-010 uio_in  in  8  pad input path.
REQ-011 uio_out  out  8  pad output path.
REQ-012 uio_oe  out  8  pad output enable; 1 means output.
REQ-013 rdata  out  8  registered copy of uio_in.
REQ-014 grant  out  NREQ  one-hot owner indication.
REQ-015 busy  out  1  high in TURN and OWN.
REQ-016 timeout  out  1  one-cycle pulse on a forced release.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, TURN and OWN.
REQ-018 In IDLE, with ena=1 and req nonzero, the block SHALL select a winner k and go to TURN on the next edge.
REQ-019 Selection SHALL be round-robin: the search starts at the index after the last owner and wraps from NREQ-1 to 0; after reset the search starts at index 0.
REQ-020 TURN SHALL last exactly one cycle with uio_oe=0 and grant=0, then go to OWN.
REQ-021 On entry to OWN, grant[k] SHALL be 1.
REQ-022 In OWN, uio_out and uio_oe SHALL be registered copies of wdata[k] and woe[k]: one cycle of latency from input to pin.
REQ-023 OWN SHALL exit to IDLE on the edge where done[k]=1 or req[k]=0.
REQ-024 On the cycle after the OWN exit, grant, uio_oe and uio_out SHALL be 0.
REQ-025 Minimum idle time between two owners SHALL be 2 cycles (IDLE plus TURN).
REQ-026 req changes by non-owners during TURN or OWN SHALL NOT affect the current owner; done from non-owners SHALL be ignored.
REQ-027 If req[k] drops during TURN, the FSM SHALL still enter OWN and then release on the following edge.
REQ-028 ena=0 in any state SHALL force IDLE on the next edge with all outputs 0 except rdata; the round-robin pointer SHALL be preserved.
REQ-029 rdata SHALL equal uio_in delayed by one cycle in every state.
REQ-030 Simultaneous done[k] and the timeout SHALL be treated as a normal release (timeout=0).

Reset
REQ-031 While rst_n=0: state=IDLE, round-robin pointer=NREQ-1, hold counter=0, and grant, uio_out, uio_oe, rdata, busy and timeout all 0.
REQ-032 Reset mid-OWN SHALL drop uio_oe to 0 asynchronously, with no glitch to 1.
REQ-033 Release of rst_n SHALL be followed by at least one IDLE cycle.

Configuration
REQ-034 With ARB_TIMEOUT_EN defined, a hold counter SHALL count OWN cycles and force OWN to IDLE after MAX_HOLD cycles, pulsing timeout for 1 cycle.
REQ-035 On a forced release, the pointer SHALL advance past the owner.
REQ-036 Without ARB_TIMEOUT_EN, there SHALL be no counter, OWN SHALL be unbounded, and timeout SHALL be tied 0.

Structure
REQ-037 Package uio_arb_pkg SHALL hold the state enum, the NREQ and MAX_HOLD defaults, and the 8-bit pin-width constant.
REQ-038 Round-robin selection SHALL live in one sub-module, rr_pick, taking req and the pointer and returning a one-hot winner and a valid flag; it is combinational.

Verification
REQ-039 Reset, ena=1, req=4'b0010, wdata[1]=8'hA5, woe[1]=8'hFF -> grant=0010 from cycle 3; uio_out=A5 and uio_oe=FF from cycle 4.
REQ-040 req=4'b1111 held, each owner pulses done after 2 OWN cycles -> grant order 0001, 0010, 0100, 1000, 0001, with 2 idle cycles between owners.
REQ-041 Owner 2 in OWN, ena drops -> next cycle grant=0 and uio_oe=0; ena returns with req=4'b1111 -> grant=1000.
REQ-042 ARB_TIMEOUT_EN with MAX_HOLD=3, req[0] held without done -> release after 3 OWN cycles, timeout=1 for 1 cycle, grant returns to 0001 after 2 cycles.
REQ-043 rst_n asserted mid-OWN with uio_oe=FF -> uio_oe=0 before the next edge; uio_in=8'h3C -> rdata=3C one cycle later.
